// File: rtl/cache_dm_param.sv
// rtl/cache_dm_param.sv - parametrised direct-mapped write-through no-write-allocate cache
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module cache_dm_param #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 2,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              renable,
  input  logic              wenable,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_renable,
  output logic              mem_wenable,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t state, state_next;

  logic [OFFSET_W-1:0] cnt;
  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tags  [LINES];
  logic [DATA_W-1:0]   words [LINES*WORDS];
  logic                store_done;

  logic [OFFSET_W-1:0] a_off;
  logic [INDEX_W-1:0]  a_idx;
  logic [TAG_W-1:0]    a_tag;
  logic                last_beat;
  logic                unused_addr_lsbs;

  assign a_off            = addr[OFFSET_W+1:2];
  assign a_idx            = addr[OFFSET_W+2 +: INDEX_W];
  assign a_tag            = addr[ADDR_W-1 -: TAG_W];
  assign unused_addr_lsbs = ^addr[1:0];
  assign last_beat        = (cnt == {OFFSET_W{1'b1}});

  assign hit   = valid[a_idx] && (tags[a_idx] == a_tag);
  assign rdata = words[{a_idx, a_off}];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // store_done marks the retire cycle of a store: the CPU still holds wenable
  // for this one cycle, and it must not launch a second memory write.
  always_comb begin
    state_next  = state;
    stall       = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_renable = 1'b0;
    mem_wenable = 1'b0;
    case (state)
      IDLE: begin
        if (wenable) begin
          if (!store_done) begin
            stall      = 1'b1;
            state_next = WRITE;
          end
        end else if (renable && !hit) begin
          stall      = 1'b1;
          state_next = REFILL;
        end
      end
      REFILL: begin
        stall       = 1'b1;
        mem_renable = 1'b1;
        mem_addr    = {a_tag, a_idx, cnt, 2'b00};
        if (mem_ready && last_beat) state_next = IDLE;
      end
      WRITE: begin
        stall       = 1'b1;
        mem_wenable = 1'b1;
        mem_addr    = {addr[ADDR_W-1:2], 2'b00};
        mem_wdata   = wdata;
        if (mem_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Valid is dropped when a refill starts and only set with the final beat,
  // so an aborted refill can never leave a partial line visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      valid      <= '0;
      store_done <= 1'b0;
    end else begin
      store_done <= (state == WRITE) && mem_ready;
      case (state)
        IDLE: begin
          if (!wenable && renable && !hit) begin
            valid[a_idx] <= 1'b0;
            cnt          <= '0;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            cnt <= cnt + 1'b1;
            if (last_beat) valid[a_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      case (state)
        REFILL: begin
          if (mem_ready) begin
            words[{a_idx, cnt}] <= mem_rdata;
            if (last_beat) tags[a_idx] <= a_tag;
          end
        end
        WRITE: begin
          if (mem_ready && hit) words[{a_idx, a_off}] <= wdata;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && renable && !wenable && hit && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'd1;
      if (state == IDLE && state_next == REFILL && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_dm_param.sv
// tb/tb_cache_dm_param.sv - scoreboard bench for cache_dm_param
module tb_cache_dm_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        renable, wenable, hit, stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_renable, mem_wenable, mem_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_dm_param dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .renable(renable), .wenable(wenable), .rdata(rdata), .hit(hit), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_renable(mem_renable),
    .mem_wenable(mem_wenable), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  logic [31:0] mem_arr [0:4095];
  assign mem_rdata = mem_renable ? mem_arr[mem_addr[13:2]] : 32'h0;
  always @(posedge clk) if (mem_wenable && mem_ready) mem_arr[mem_addr[13:2]] = mem_wdata;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;
  localparam logic [1:0] EV_RD = 2'd0, EV_WR = 2'd1, EV_LD = 2'd2;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ev_t mk_ev(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.a = a; e.d = d;
    return e;
  endfunction

  // Monitor: every memory beat and every completed load is popped against the queue.
  always @(negedge clk) begin
    ev_t  obs;
    ev_t  e;
    logic seen;
    if (mon_en) begin
      seen = 1'b0;
      obs  = '0;
      check("mem_exclusive", {31'b0, mem_renable & mem_wenable}, 32'h0);
      if (mem_renable && mem_ready) begin
        obs = mk_ev(EV_RD, mem_addr, 32'h0); seen = 1'b1;
      end else if (mem_wenable && mem_ready) begin
        obs = mk_ev(EV_WR, mem_addr, mem_wdata); seen = 1'b1;
      end else if (renable && !wenable && !stall && hit) begin
        obs = mk_ev(EV_LD, addr, rdata); seen = 1'b1;
      end
      if (seen) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d addr %h data %h expected none", obs.kind, obs.a, obs.d);
        end else begin
          e = exp_q.pop_front();
          check("ev_kind", {30'b0, obs.kind}, {30'b0, e.kind});
          check("ev_addr", obs.a, e.a);
          check("ev_data", obs.d, e.d);
        end
      end
    end
  end

  // pat bit k is mem_ready for the k-th cycle after the request cycle.
  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input bit miss,
                         input logic [7:0] pat, input int plen, input int exp_cyc);
    int cyc;
    int k;
    if (miss) for (int i = 0; i < 4; i++) exp_q.push_back(mk_ev(EV_RD, (a & ~32'hF) + 32'(4*i), 32'h0));
    exp_q.push_back(mk_ev(EV_LD, a, exp_d));
    @(posedge clk); #1;
    addr = a; renable = 1'b1; wenable = 1'b0; mem_ready = 1'b1;
    cyc = 0; k = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      cyc++;
      if (cyc > 64) begin
        n_checks++; n_fail++;
        $display("FAIL read_timeout: got stall after %0d cycles expected release", cyc);
        break;
      end
      @(posedge clk); #1;
      mem_ready = (k < plen) ? pat[k] : 1'b1;
      k++;
    end
    check("read_stall_cycles", cyc, exp_cyc);
    @(posedge clk); #1;
    renable = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int cyc;
    exp_q.push_back(mk_ev(EV_WR, a, d));
    @(posedge clk); #1;
    addr = a; wdata = d; wenable = 1'b1; renable = 1'b0; mem_ready = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      cyc++;
      if (cyc > 64) begin
        n_checks++; n_fail++;
        $display("FAIL write_timeout: got stall after %0d cycles expected release", cyc);
        break;
      end
      @(posedge clk); #1;
    end
    check("write_stall_cycles", cyc, 2);
    @(posedge clk); #1;
    wenable = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall"}, {31'b0, stall}, 32'h0);
    check({tag, "_mem_renable"}, {31'b0, mem_renable}, 32'h0);
    check({tag, "_mem_wenable"}, {31'b0, mem_wenable}, 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_hit"}, {31'b0, hit}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_arr[i] = 32'h5000_0000 | i;
    for (int i = 0; i < 4; i++) begin
      mem_arr[16 + i] = 32'hA0 + i;
      mem_arr[32 + i] = 32'hB0 + i;
      mem_arr[48 + i] = 32'hC0 + i;
    end
    rst = 1'b0; addr = 32'h0; wdata = 32'h0; renable = 1'b0; wenable = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; mon_en = 1'b1; addr = 32'h40;
    @(negedge clk);
    check_idle_outputs("reset");
`ifdef CACHE_STATS_EN
    check("reset_hit_count", hit_count, 32'h0);
    check("reset_miss_count", miss_count, 32'h0);
`endif

    do_read(32'h40, 32'hA0, 1'b1, 8'hFF, 0, 5);
    do_read(32'h48, 32'hA2, 1'b0, 8'hFF, 0, 0);
    do_read(32'h40, 32'hA0, 1'b0, 8'hFF, 0, 0);
`ifdef CACHE_STATS_EN
    check("stats_hit_count", hit_count, 32'd3);
    check("stats_miss_count", miss_count, 32'd1);
`endif

    do_write(32'h44, 32'hDEAD);
`ifdef CACHE_STATS_EN
    check("store_hit_count", hit_count, 32'd3);
    check("store_miss_count", miss_count, 32'd1);
`endif
    do_read(32'h44, 32'hDEAD, 1'b0, 8'hFF, 0, 0);

    do_write(32'h1044, 32'hBEEF);
    do_read(32'h44, 32'hDEAD, 1'b0, 8'hFF, 0, 0);

    // ready pattern 1,0,0,1,1,0,1: seven refill cycles plus the request cycle
    do_read(32'hC0, 32'hC0, 1'b1, 8'h59, 7, 8);
    do_read(32'hCC, 32'hC3, 1'b0, 8'hFF, 0, 0);

    exp_q.push_back(mk_ev(EV_RD, 32'h80, 32'h0));
    exp_q.push_back(mk_ev(EV_RD, 32'h84, 32'h0));
    @(posedge clk); #1;
    addr = 32'h80; renable = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; renable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    do_read(32'h80, 32'hB0, 1'b1, 8'hFF, 0, 5);
    do_read(32'h8C, 32'hB3, 1'b0, 8'hFF, 0, 0);

    repeat (2) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
